// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - pixel request and timing configuration bundle
interface vga_sync_gen_if;
  logic        req_valid;
  logic [10:0] req_x;
  logic [10:0] req_y;
  logic [7:0]  pix_r;
  logic [7:0]  pix_g;
  logic [7:0]  pix_b;

  logic        cfg_wr;
  logic        cfg_sel;
  logic [10:0] cfg_active;
  logic [7:0]  cfg_fp;
  logic [7:0]  cfg_sync;
  logic [7:0]  cfg_bp;
  logic        cfg_err;

  modport master (
    output req_valid, req_x, req_y, cfg_err,
    input  pix_r, pix_g, pix_b,
    input  cfg_wr, cfg_sel, cfg_active, cfg_fp, cfg_sync, cfg_bp
  );

  modport slave (
    input  req_valid, req_x, req_y, cfg_err,
    output pix_r, pix_g, pix_b,
    output cfg_wr, cfg_sel, cfg_active, cfg_fp, cfg_sync, cfg_bp
  );
endinterface

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA timing generator with shadowed timing and 2-cycle output pipeline
module vga_sync_gen #(
  parameter int HOR_ACT   = 640,
  parameter int HOR_FP    = 16,
  parameter int HOR_SYNC  = 96,
  parameter int HOR_BP    = 48,
  parameter int VERT_ACT  = 480,
  parameter int VERT_FP   = 11,
  parameter int VERT_SYNC = 2,
  parameter int VERT_BP   = 31,
  parameter bit SYNC_POL  = 1'b1
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic              en,
  vga_sync_gen_if.master    bus,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              line_start,
  output logic              frame_start
);

  typedef struct packed {
    logic [10:0] act;
    logic [7:0]  fp;
    logic [7:0]  sync;
    logic [7:0]  bp;
  } timing_t;

  localparam timing_t H_DEF = {11'(HOR_ACT), 8'(HOR_FP), 8'(HOR_SYNC), 8'(HOR_BP)};
  localparam timing_t V_DEF = {11'(VERT_ACT), 8'(VERT_FP), 8'(VERT_SYNC), 8'(VERT_BP)};

  timing_t     h_cur, v_cur, h_sh, v_sh, h_sh_nxt, v_sh_nxt, cfg_val;
  logic [10:0] hcnt, vcnt;
  logic [11:0] h_last, v_last, h_sync_lo, h_sync_hi, v_sync_lo, v_sync_hi;
  logic        h_end, v_end, hs_on, vs_on, cfg_ok, req_on;
  logic        hs_d1, vs_d1, de_d1, ls_d1, fs_d1;

  // Totals are 12 bit so act + porches + sync cannot wrap.
  assign h_last    = 12'(h_cur.act) + 12'(h_cur.fp) + 12'(h_cur.sync) + 12'(h_cur.bp) - 12'd1;
  assign v_last    = 12'(v_cur.act) + 12'(v_cur.fp) + 12'(v_cur.sync) + 12'(v_cur.bp) - 12'd1;
  assign h_sync_lo = 12'(h_cur.act) + 12'(h_cur.fp);
  assign h_sync_hi = h_sync_lo + 12'(h_cur.sync);
  assign v_sync_lo = 12'(v_cur.act) + 12'(v_cur.fp);
  assign v_sync_hi = v_sync_lo + 12'(v_cur.sync);

  assign h_end = ({1'b0, hcnt} == h_last);
  assign v_end = ({1'b0, vcnt} == v_last);
  assign hs_on = ({1'b0, hcnt} >= h_sync_lo) && ({1'b0, hcnt} < h_sync_hi);
  assign vs_on = ({1'b0, vcnt} >= v_sync_lo) && ({1'b0, vcnt} < v_sync_hi);

  assign req_on        = en && (hcnt < h_cur.act) && (vcnt < v_cur.act);
  assign bus.req_valid = req_on;
  assign bus.req_x     = hcnt;
  assign bus.req_y     = vcnt;

  assign cfg_val = {bus.cfg_active, bus.cfg_fp, bus.cfg_sync, bus.cfg_bp};
  assign cfg_ok  = bus.cfg_wr && (bus.cfg_active != 11'd0) && (bus.cfg_sync != 8'd0);

  always_comb begin
    h_sh_nxt = h_sh;
    v_sh_nxt = v_sh;
    if (cfg_ok && !bus.cfg_sel) h_sh_nxt = cfg_val;
    if (cfg_ok && bus.cfg_sel)  v_sh_nxt = cfg_val;
  end

  // At the frame boundary the pre-write shadow is applied; while idle a write lands at once.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      hcnt        <= 11'd0;
      vcnt        <= 11'd0;
      h_cur       <= H_DEF;
      v_cur       <= V_DEF;
      h_sh        <= H_DEF;
      v_sh        <= V_DEF;
      bus.cfg_err <= 1'b0;
    end else begin
      h_sh        <= h_sh_nxt;
      v_sh        <= v_sh_nxt;
      bus.cfg_err <= bus.cfg_wr && !cfg_ok;
      if (!en) begin
        hcnt  <= 11'd0;
        vcnt  <= 11'd0;
        h_cur <= h_sh_nxt;
        v_cur <= v_sh_nxt;
      end else if (h_end) begin
        hcnt <= 11'd0;
        if (v_end) begin
          vcnt  <= 11'd0;
          h_cur <= h_sh;
          v_cur <= v_sh;
        end else begin
          vcnt <= vcnt + 11'd1;
        end
      end else begin
        hcnt <= hcnt + 11'd1;
      end
    end
  end

  // Stage 1 aligns counter state with the source's one-cycle pixel latency.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      hs_d1 <= 1'b0;
      vs_d1 <= 1'b0;
      de_d1 <= 1'b0;
      ls_d1 <= 1'b0;
      fs_d1 <= 1'b0;
    end else begin
      hs_d1 <= en && hs_on;
      vs_d1 <= en && vs_on;
      de_d1 <= req_on;
      ls_d1 <= en && (hcnt == 11'd0);
      fs_d1 <= en && (hcnt == 11'd0) && (vcnt == 11'd0);
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst || !en) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      r           <= 8'd0;
      g           <= 8'd0;
      b           <= 8'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_d1 ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_d1 ? SYNC_POL : ~SYNC_POL;
      de          <= de_d1;
      r           <= de_d1 ? bus.pix_r : 8'd0;
      g           <= de_d1 ? bus.pix_g : 8'd0;
      b           <= de_d1 ? bus.pix_b : 8'd0;
      line_start  <= ls_d1;
      frame_start <= fs_d1;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed bench for vga_sync_gen on a 14x8 timing
module tb_vga_sync_gen;
  logic       pixel_clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] r, g, b;
  logic       hsync, vsync, de, line_start, frame_start;

  vga_sync_gen_if vif ();

  vga_sync_gen #(
    .HOR_ACT(8), .HOR_FP(2), .HOR_SYNC(3), .HOR_BP(1),
    .VERT_ACT(4), .VERT_FP(1), .VERT_SYNC(2), .VERT_BP(1),
    .SYNC_POL(1'b1)
  ) dut (
    .pixel_clk  (pixel_clk),
    .rst        (rst),
    .en         (en),
    .bus        (vif.master),
    .r          (r),
    .g          (g),
    .b          (b),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .line_start (line_start),
    .frame_start(frame_start)
  );

  always #5 pixel_clk = ~pixel_clk;

  // One-cycle pixel source: r carries x, g carries y.
  always @(posedge pixel_clk) begin
    vif.pix_r <= vif.req_x[7:0];
    vif.pix_g <= vif.req_y[7:0];
    vif.pix_b <= 8'h5a;
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic       c_hs[400], c_vs[400], c_de[400], c_ls[400], c_fs[400], c_err[400], c_rv[400];
  logic [7:0] c_r[400], c_g[400];
  logic [10:0] c_x[400];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic restart();
    rst = 1'b1;
    en  = 1'b0;
    vif.cfg_wr = 1'b0;
    tick();
    rst = 1'b0;
    en  = 1'b1;
  endtask

  // Index 0 is the first en=1 cycle after restart(); the counter is (0,0) there.
  task automatic run(input int n, input int wr_at, input logic [10:0] wr_act,
                     input logic [7:0] wr_sync, input int off_at, input int off_len,
                     input int rst_at);
    for (int i = 0; i < n; i++) begin
      vif.cfg_wr     = (i == wr_at);
      vif.cfg_sel    = 1'b0;
      vif.cfg_active = wr_act;
      vif.cfg_fp     = 8'd2;
      vif.cfg_sync   = wr_sync;
      vif.cfg_bp     = 8'd1;
      en  = !((i >= off_at) && (i < off_at + off_len));
      rst = (i == rst_at);
      #1;
      c_hs[i] = hsync;  c_vs[i] = vsync;  c_de[i] = de;
      c_ls[i] = line_start;  c_fs[i] = frame_start;  c_err[i] = vif.cfg_err;
      c_rv[i] = vif.req_valid;  c_x[i] = vif.req_x;
      c_r[i]  = r;  c_g[i] = g;
      @(posedge pixel_clk);
      #1;
    end
    vif.cfg_wr = 1'b0;
    rst = 1'b0;
  endtask

  function automatic int count_sig(input int sel, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) begin
      case (sel)
        0: c += int'(c_de[i]);
        1: c += int'(c_hs[i]);
        2: c += int'(c_vs[i]);
        3: c += int'(c_fs[i]);
        default: c += int'(c_err[i]);
      endcase
    end
    return c;
  endfunction

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    vif.cfg_wr = 1'b0;  vif.cfg_sel = 1'b0;
    vif.cfg_active = 11'd0;  vif.cfg_fp = 8'd0;  vif.cfg_sync = 8'd0;  vif.cfg_bp = 8'd0;
    repeat (3) tick();
    check("rst_hsync", hsync, 0);
    check("rst_vsync", vsync, 0);
    check("rst_de", de, 0);
    check("rst_r", r, 0);
    check("rst_ls", line_start, 0);
    check("rst_fs", frame_start, 0);
    check("rst_cfg_err", vif.cfg_err, 0);
    check("rst_req_valid", vif.req_valid, 0);

    // Default 14x8 frame, no writes.
    restart();
    run(230, -1, 11'd0, 8'd0, -1, 0, -1);
    check("rv_x0", c_rv[0], 1);
    check("rv_x8", c_rv[8], 0);
    check("x_at_5", c_x[5], 5);
    check("fs_first", c_fs[2], 1);
    check("fs_before", c_fs[1], 0);
    check("fs_period", c_fs[114], 1);
    check("fs_count", count_sig(3, 0, 229), 3);
    check("ls_line1", c_ls[16], 1);
    check("de_per_frame", count_sig(0, 2, 113), 32);
    check("hs_per_frame", count_sig(1, 2, 113), 24);
    check("vs_per_frame", count_sig(2, 2, 113), 28);
    check("hs_h9", c_hs[11], 0);
    check("hs_h10", c_hs[12], 1);
    check("hs_h12", c_hs[14], 1);
    check("hs_h13", c_hs[15], 0);
    check("vs_l4_end", c_vs[71], 0);
    check("vs_l5", c_vs[72], 1);
    check("vs_l6_end", c_vs[99], 1);
    check("vs_l7", c_vs[100], 0);
    check("pix32_de", c_de[33], 1);
    check("pix32_r", c_r[33], 3);
    check("pix32_g", c_g[33], 2);
    check("blank_r", c_r[12], 0);

    // Mid-frame write of active=6 takes effect on the following frame.
    restart();
    run(230, 20, 11'd6, 8'd3, -1, 0, -1);
    check("mid_fs2", c_fs[114], 1);
    check("mid_de_f1", count_sig(0, 2, 113), 32);
    check("mid_de_f2", count_sig(0, 114, 209), 24);
    check("mid_fs3", c_fs[210], 1);
    check("mid_ls", c_ls[126], 1);
    check("mid_ls_off", c_ls[128], 0);
    check("mid_hs_h7", c_hs[121], 0);
    check("mid_hs_h8", c_hs[122], 1);
    check("mid_hs_h11", c_hs[125], 0);

    // Write exactly on the boundary cycle is deferred by one frame.
    restart();
    run(330, 111, 11'd6, 8'd3, -1, 0, -1);
    check("bnd_fs2", c_fs[114], 1);
    check("bnd_fs3", c_fs[226], 1);
    check("bnd_de_f2", count_sig(0, 114, 225), 32);
    check("bnd_ls", c_ls[238], 1);
    check("bnd_ls_off", c_ls[240], 0);
    check("bnd_fs4", c_fs[322], 1);

    // Rejected write: active=0.
    restart();
    run(240, 50, 11'd0, 8'd3, -1, 0, -1);
    check("err_before", c_err[50], 0);
    check("err_pulse", c_err[51], 1);
    check("err_after", c_err[52], 0);
    check("err_count", count_sig(4, 0, 239), 1);
    check("err_fs2", c_fs[114], 1);
    check("err_fs3", c_fs[226], 1);

    // Enable dropped at (5,2) for three cycles; also a rejected sync=0 write.
    restart();
    run(60, 10, 11'd8, 8'd0, 33, 3, -1);
    check("sync0_err", c_err[11], 1);
    check("dis_rv", c_rv[33], 0);
    check("dis_de34", c_de[34], 0);
    check("dis_de36", c_de[36], 0);
    check("dis_hs35", c_hs[35], 0);
    check("dis_fs37", c_fs[37], 0);
    check("reen_fs", c_fs[38], 1);
    check("reen_de", c_de[38], 1);
    check("reen_r", c_r[38], 0);

    // Reset mid-line discards a pending shadow write and restarts at (0,0).
    restart();
    run(160, 10, 11'd6, 8'd3, -1, 0, 33);
    check("mrst_de", c_de[34], 0);
    check("mrst_r", c_r[34], 0);
    check("mrst_x0", c_x[34], 0);
    check("mrst_x1", c_x[35], 1);
    check("mrst_fs_early", c_fs[35], 0);
    check("mrst_fs", c_fs[36], 1);
    check("mrst_no_short", c_fs[132], 0);
    check("mrst_fs_next", c_fs[148], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter HOR_ACT, default 640: active pixels per line.
REQ-002 SHALL have parameters HOR_FP/HOR_SYNC/HOR_BP, defaults 16/96/48: horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter VERT_ACT, default 480: active lines per frame.
REQ-004 SHALL have parameters VERT_FP/VERT_SYNC/VERT_BP, defaults 11/2/31: vertical porch and sync widths in lines.
REQ-005 SHALL have parameter SYNC_POL, default 1: asserted level of hsync/vsync.
REQ-006 SHALL have one clock and a synchronous active-high reset: pixel_clk input 1, rising-edge pixel clock; rst input 1, synchronous active-high reset.
REQ-007 Port en, input, 1: timing generator enable.
REQ-008 Ports cfg_wr input 1 (write strobe) and cfg_sel input 1 (0=horizontal, 1=vertical).
REQ-009 Ports cfg_active input 11, and cfg_fp/cfg_sync/cfg_bp input 8 each: new timing values.
REQ-010 Port cfg_err, output, 1: rejected-write pulse.
REQ-011 Ports req_valid output 1, req_x output 11, req_y output 11: pixel request to the pixel source.
REQ-012 Ports pix_r/pix_g/pix_b, input, 8 each: source data, valid exactly 1 cycle after req_valid.
REQ-013 Ports r/g/b output 8 each; hsync/vsync output 1; de output 1: registered VGA output.
REQ-014 Ports line_start and frame_start, output, 1 each: single-cycle pulses.

Function
REQ-015 Line order SHALL be active, front porch, sync, back porch; htotal = act+fp+sync+bp; hcnt SHALL run 0..htotal-1, 11 bit.
REQ-016 Frame order SHALL be the same in lines; vcnt SHALL run 0..vtotal-1; vcnt SHALL increment when hcnt wraps to 0, and wrap to 0 after vtotal-1.
REQ-017 req_valid SHALL be combinational: hcnt<h.act AND vcnt<v.act AND en; req_x=hcnt, req_y=vcnt.
REQ-018 Counter state of cycle t SHALL appear on hsync/vsync/de/r/g/b in cycle t+2 (fixed 2-cycle latency).
REQ-019 hsync SHALL be at SYNC_POL for hcnt in [act+fp, act+fp+sync-1]; vsync likewise over vcnt.
REQ-020 de SHALL equal the delayed req_valid; r/g/b SHALL be pix_* when de=1, else 0.
REQ-021 line_start SHALL pulse on the output cycle for hcnt=0; frame_start SHALL pulse when hcnt=0 and vcnt=0; both pulses use the 2-cycle alignment.
REQ-022 cfg_wr SHALL load a horizontal or vertical shadow register set, chosen by cfg_sel.
REQ-023 Shadow registers SHALL transfer to the active timing only at the frame boundary (hcnt=htotal-1 and vcnt=vtotal-1), or immediately while en=0.
REQ-024 If cfg_wr coincides with the frame boundary, the pre-write shadow SHALL be applied; the new value SHALL apply at the next boundary.
REQ-025 cfg_wr with cfg_active=0 or cfg_sync=0 SHALL be ignored (shadow unchanged), and cfg_err SHALL pulse high the next cycle.
REQ-026 en=0 SHALL hold hcnt=vcnt=0 and force req_valid=0; output registers SHALL load sync inactive, de=0, rgb=0 each cycle.
REQ-027 On en rising, counting SHALL start at (0,0) in the first en=1 cycle; outputs SHALL follow after 2 cycles.

Reset
REQ-028 On rst: hcnt=vcnt=0; hsync=vsync=~SYNC_POL; de=0; r=g=b=0; line_start=frame_start=cfg_err=0.
REQ-029 On rst: active and shadow timing SHALL reload the parameter defaults; the pipeline SHALL be flushed.
REQ-030 rst SHALL take priority over en and cfg_wr; mid-frame rst SHALL restart at (0,0) after release.

Verification
REQ-031 H=8/2/3/1, V=4/1/2/1, en=1 -> htotal 14, vtotal 8; hsync asserted output cycles for hcnt 10..12; vsync lines 5..6; de 32 cycles/frame.
REQ-032 pix_r=req_x, pix_g=req_y (1-cycle source) -> output pixel (3,2) has r=3, g=2, coincident with de; frame_start every 112 cycles.
REQ-033 cfg_wr sel=0 active=6 mid-frame -> current frame keeps 8 pixels/line; the next frame has 6 and htotal 12.
REQ-034 cfg_wr exactly on the boundary cycle -> the value applies one frame later; cfg_wr with active=0 -> cfg_err one pulse, timing unchanged.
REQ-035 en low at hcnt=5,vcnt=2 for 3 cycles -> outputs inactive, de=0; on re-enable, frame_start 2 cycles after the first en=1 cycle.
REQ-036 rst mid-line -> the next cycle shows reset values; after release the sequence restarts at (0,0) with the default timing.
